// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus definitions: opcode bytes that matter to interrupt
// controllers and the encoding of the M1 prefix-tracking state.
package z80_bus_pkg;

  localparam logic [7:0] OP_CB    = 8'hCB;
  localparam logic [7:0] OP_ED    = 8'hED;
  localparam logic [7:0] OP_DD    = 8'hDD;
  localparam logic [7:0] OP_FD    = 8'hFD;
  localparam logic [7:0] OP_RETI2 = 8'h4D;
  localparam logic [7:0] OP_RETN2 = 8'h45;

  typedef enum logic [1:0] {
    NORM = 2'd0,
    CBP  = 2'd1,
    IXP  = 2'd2,
    EDP  = 2'd3
  } pfx_state_t;

endpackage

// File: rtl/z80_op_decoder.sv
// Snoops M1 opcode fetches, tracks CB/DD/FD/ED prefixes and flags RETI/RETN.
// O_RETI_HIT marks the enabled edge that decodes RETI; O_RETI/O_RETN are the registered pulses.
module z80_op_decoder
  import z80_bus_pkg::*;
(
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_CLKEN,
  input  logic       I_M1_n,
  input  logic       I_MREQ_n,
  input  logic [7:0] I_D,
  output logic       O_RETI,
  output logic       O_RETN,
  output logic       O_RETI_HIT,
  output logic [1:0] O_STATE
);

  pfx_state_t state, state_nxt;
  logic       fetch, fetch_r, fetch_end;
  logic [7:0] op;
  logic       reti_nxt, retn_nxt;

  assign fetch     = ~I_M1_n & ~I_MREQ_n;
  assign fetch_end = fetch_r & ~fetch;

  always_comb begin
    state_nxt = state;
    reti_nxt  = 1'b0;
    retn_nxt  = 1'b0;
    if (fetch_end) begin
      unique case (state)
        NORM: begin
          if (op == OP_CB)                      state_nxt = CBP;
          else if (op == OP_ED)                 state_nxt = EDP;
          else if (op == OP_DD || op == OP_FD)  state_nxt = IXP;
          else                                  state_nxt = NORM;
        end
        // DD CB d op: displacement and opcode are plain reads, so the instruction ends here.
        IXP: begin
          if (op == OP_ED)                      state_nxt = EDP;
          else if (op == OP_DD || op == OP_FD)  state_nxt = IXP;
          else                                  state_nxt = NORM;
        end
        CBP: state_nxt = NORM;
        EDP: begin
          state_nxt = NORM;
          reti_nxt  = (op == OP_RETI2);
          retn_nxt  = (op == OP_RETN2);
        end
        default: state_nxt = NORM;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state   <= NORM;
      fetch_r <= 1'b0;
      op      <= 8'h00;
      O_RETI  <= 1'b0;
      O_RETN  <= 1'b0;
    end else if (I_CLKEN) begin
      fetch_r <= fetch;
      if (fetch) op <= I_D;
      state   <= state_nxt;
      O_RETI  <= reti_nxt;
      O_RETN  <= retn_nxt;
    end
  end

  assign O_RETI_HIT = I_CLKEN & reti_nxt;
  assign O_STATE    = state;

endmodule

// File: rtl/z80_daisy_ctrl.sv
// Z80 mode-2 daisy-chain interrupt controller for NCH local channels
// (channel 0 highest priority): IEI/IEO chain, INT_n, INTA vector and RETI service release.
module z80_daisy_ctrl
  import z80_bus_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic             I_CLK,
  input  logic             I_RESET,
  input  logic             I_CLKEN,
  input  logic             I_M1_n,
  input  logic             I_MREQ_n,
  input  logic             I_IORQ_n,
  input  logic [7:0]       I_D,
  input  logic             I_IEI,
  input  logic [NCH-1:0]   I_REQ,
  input  logic [8*NCH-1:0] I_VEC,
  output logic             O_INT_n,
  output logic             O_IEO,
  output logic [7:0]       O_VEC,
  output logic             O_VEC_OE,
  output logic [NCH-1:0]   O_ACK,
  output logic [NCH-1:0]   O_SVC,
  output logic             O_RETI,
  output logic             O_RETN
);

  logic           fetch, inta, inta_r, reti_hit;
  logic [NCH:0]   ie;
  logic [NCH-1:0] pend, svc, ack_r, elig, ack_sel, rel_sel;
  logic [7:0]     vec_nxt;
  logic [1:0]     dec_state;

  assign fetch = ~I_M1_n & ~I_MREQ_n;
  assign inta  = ~I_M1_n & ~I_IORQ_n;

  z80_op_decoder u_dec (
    .I_CLK      (I_CLK),
    .I_RESET    (I_RESET),
    .I_CLKEN    (I_CLKEN),
    .I_M1_n     (I_M1_n),
    .I_MREQ_n   (I_MREQ_n),
    .I_D        (I_D),
    .O_RETI     (O_RETI),
    .O_RETN     (O_RETN),
    .O_RETI_HIT (reti_hit),
    .O_STATE    (dec_state)
  );

  // A pending channel blocks lower channels during an M1 fetch so the chain settles before INTA.
  always_comb begin
    logic run;
    run = I_IEI;
    ie  = '0;
    for (int i = 0; i < NCH; i++) begin
      ie[i] = run;
      run   = run & ~svc[i] & ~(pend[i] & fetch);
    end
    ie[NCH] = run;
  end

  assign elig = pend & ie[NCH-1:0];

  always_comb begin
    logic got_ack, got_rel;
    ack_sel = '0;
    rel_sel = '0;
    vec_nxt = 8'h00;
    got_ack = 1'b0;
    got_rel = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (elig[i] && !got_ack) begin
        ack_sel[i] = 1'b1;
        vec_nxt    = I_VEC[8*i +: 8];
        got_ack    = 1'b1;
      end
      if (svc[i] && ie[i] && !got_rel) begin
        rel_sel[i] = 1'b1;
        got_rel    = 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      pend     <= '0;
      svc      <= '0;
      ack_r    <= '0;
      inta_r   <= 1'b0;
      O_VEC    <= 8'h00;
      O_VEC_OE <= 1'b0;
    end else if (I_CLKEN) begin
      inta_r <= inta;
      ack_r  <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (!svc[i] && !inta) pend[i] <= I_REQ[i];
      end
      if (inta && !inta_r && (|ack_sel)) begin
        pend     <= pend & ~ack_sel;
        svc      <= svc | ack_sel;
        ack_r    <= ack_sel;
        O_VEC    <= vec_nxt;
        O_VEC_OE <= 1'b1;
      end else if (!inta) begin
        O_VEC_OE <= 1'b0;
      end
      // INTA and a fetch end never coincide, so this cannot collide with an acknowledge.
      if (reti_hit) svc <= svc & ~rel_sel;
    end
  end

  assign O_IEO   = ie[NCH];
  assign O_INT_n = ~|elig;
  assign O_ACK   = ack_r;
  assign O_SVC   = svc;

endmodule

// File: tb/tb_z80_daisy_ctrl.sv
// Bench for z80_daisy_ctrl: directed bus sequences plus randomized traffic checked
// against an instruction-level opcode parser and a priority-chain model.
module tb_z80_daisy_ctrl;
  import z80_bus_pkg::*;

  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             rst, clken = 1'b0;
  logic             m1_n, mreq_n, iorq_n;
  logic [7:0]       d;
  logic             iei;
  logic [NCH-1:0]   req;
  logic [8*NCH-1:0] vec;
  logic             int_n, ieo, vec_oe, reti, retn;
  logic [7:0]       vec_o;
  logic [NCH-1:0]   ack, svc;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  hist[$];
  logic [3:0]  m_svc;

  z80_daisy_ctrl #(.NCH(NCH)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_CLKEN(clken),
    .I_M1_n(m1_n), .I_MREQ_n(mreq_n), .I_IORQ_n(iorq_n), .I_D(d),
    .I_IEI(iei), .I_REQ(req), .I_VEC(vec),
    .O_INT_n(int_n), .O_IEO(ieo), .O_VEC(vec_o), .O_VEC_OE(vec_oe),
    .O_ACK(ack), .O_SVC(svc), .O_RETI(reti), .O_RETN(retn)
  );

  // clock / clock-enable
  always #5 clk = ~clk;
  always @(negedge clk) clken = ($urandom_range(0, 3) != 0);

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next enabled clock edge
  task automatic en_cycle();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!clken && n < 64);
    if (!clken) chk("clken_timeout", 0, 1);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Parses the M1 byte stream into instructions; returns 1 if the last byte
  // completes RETI, 2 if it completes RETN, else 0.
  function automatic int classify_last();
    int i = 0;
    int n = hist.size();
    int r = 0;
    bit ix = 0;
    while (i < n) begin
      if (hist[i] == 8'hDD || hist[i] == 8'hFD) begin
        ix = 1; i++;
      end else if (hist[i] == 8'hCB) begin
        i  = ix ? i + 1 : i + 2;
        ix = 0;
      end else if (hist[i] == 8'hED) begin
        if (i + 1 == n - 1) r = (hist[i+1] == 8'h4D) ? 1 : (hist[i+1] == 8'h45) ? 2 : 0;
        i += 2; ix = 0;
      end else begin
        i++; ix = 0;
      end
    end
    return r;
  endfunction

  function automatic int model_ack_ch();
    if (!iei) return -1;
    for (int i = 0; i < NCH; i++) begin
      if (m_svc[i]) return -1;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic model_int_n();
    return (model_ack_ch() < 0);
  endfunction

  task automatic model_reti();
    if (iei) begin
      for (int i = 0; i < NCH; i++) begin
        if (m_svc[i]) begin
          m_svc[i] = 1'b0;
          break;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    chk({tag, "_int_n"}, int_n, model_int_n());
    chk({tag, "_ieo"}, ieo, iei && (m_svc == 0));
    chk({tag, "_svc"}, svc, m_svc);
  endtask

  task automatic set_req(input logic [3:0] v);
    req = v;
    en_cycle();
    en_cycle();
  endtask

  task automatic m1_fetch(input logic [7:0] b);
    int kind;
    m1_n = 0; mreq_n = 0; d = b;
    en_cycle();
    en_cycle();
    m1_n = 1; mreq_n = 1; d = 8'hFF;
    hist.push_back(b);
    kind = classify_last();
    en_cycle();
    chk("reti_pulse", reti, kind == 1);
    chk("retn_pulse", retn, kind == 2);
    if (kind == 1) model_reti();
    en_cycle();
    chk("pulse_end", {reti, retn}, 2'b00);
    chk("svc_after_fetch", svc, m_svc);
  endtask

  task automatic mem_read(input logic [7:0] b);
    mreq_n = 0; d = b;
    en_cycle();
    en_cycle();
    mreq_n = 1; d = 8'hFF;
    en_cycle();
  endtask

  task automatic do_inta();
    int k = model_ack_ch();
    m1_n = 0; iorq_n = 0;
    en_cycle();
    if (k >= 0) begin
      exp_q.push_back(vec[8*k +: 8]);
      m_svc[k] = 1'b1;
      chk("ack", ack, 4'b0001 << k);
      chk("vec_oe", vec_oe, 1);
      chk("vec", vec_o, exp_q.pop_front());
    end else begin
      chk("ack_none", ack, 0);
      chk("vec_oe_none", vec_oe, 0);
    end
    en_cycle();
    chk("ack_end", ack, 0);
    chk("vec_oe_hold", vec_oe, k >= 0);
    m1_n = 1; iorq_n = 1;
    en_cycle();
    chk("vec_oe_release", vec_oe, 0);
    chk("svc_after_inta", svc, m_svc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pool [8];
    pool[0] = 8'hCB; pool[1] = 8'hED; pool[2] = 8'hDD; pool[3] = 8'hFD;
    pool[4] = 8'h4D; pool[5] = 8'h45; pool[6] = 8'h00; pool[7] = 8'h3E;

    rst = 1; m1_n = 1; mreq_n = 1; iorq_n = 1; d = 8'hFF;
    iei = 0; req = 4'hF; vec = 32'h30_24_12_08; m_svc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ieo_low", ieo, 0);
    iei = 1;
    #1;
    chk("rst_int_n", int_n, 1);
    chk("rst_vec_oe", vec_oe, 0);
    chk("rst_vec", vec_o, 0);
    chk("rst_ack", ack, 0);
    chk("rst_svc", svc, 0);
    chk("rst_reti_retn", {reti, retn}, 0);
    chk("rst_ieo_high", ieo, 1);
    chk("rst_state", dut.u_dec.O_STATE, NORM);
    req = 0;
    rst = 0;
    en_cycle();

    // channel 2 request and acknowledge
    set_req(4'b0100);
    chk("t1_int_n", int_n, 0);
    do_inta();
    chk("t1_svc", svc, 4'b0100);
    chk("t1_ieo", ieo, 0);
    set_req(4'b0000);

    // RETI releases channel 2
    m1_fetch(8'hED);
    m1_fetch(8'h4D);
    check_idle("t2");
    chk("t2_ieo", ieo, 1);

    // prefix sequences
    m1_fetch(8'hCB); m1_fetch(8'hED); m1_fetch(8'h4D);
    m1_fetch(8'hDD); m1_fetch(8'hCB); mem_read(8'h05); mem_read(8'h4D);
    m1_fetch(8'hED); m1_fetch(8'h4D);
    m1_fetch(8'hDD); m1_fetch(8'hED); m1_fetch(8'h4D);

    // RETN leaves service untouched
    set_req(4'b0010);
    do_inta();
    set_req(4'b0000);
    m1_fetch(8'hED); m1_fetch(8'h45);
    chk("retn_svc", svc, 4'b0010);
    m1_fetch(8'hED); m1_fetch(8'h4D);
    check_idle("t3");

    // nesting: channel 3 in service, channel 1 preempts
    set_req(4'b1000);
    do_inta();
    set_req(4'b0010);
    chk("nest_int_n", int_n, 0);
    do_inta();
    chk("nest_svc", svc, 4'b1010);
    set_req(4'b0000);
    m1_fetch(8'hED); m1_fetch(8'h4D);
    chk("nest_reti1", svc, 4'b1000);
    m1_fetch(8'hED); m1_fetch(8'h4D);
    chk("nest_reti2", svc, 4'b0000);

    // chain disabled from upstream
    iei = 0;
    set_req(4'b0001);
    chk("iei0_int_n", int_n, 1);
    chk("iei0_ieo", ieo, 0);
    do_inta();
    iei = 1;
    set_req(4'b0000);

    // reset in the middle of INTA with two channels in service
    m1_fetch(8'hED);
    set_req(4'b0010);
    do_inta();
    set_req(4'b0001);
    m1_n = 0; iorq_n = 0;
    en_cycle();
    chk("mid_svc", svc, 4'b0011);
    chk("mid_vec_oe", vec_oe, 1);
    chk("mid_state", dut.u_dec.O_STATE, EDP);
    req = 0; rst = 1;
    @(posedge clk);
    #1;
    chk("rrst_vec_oe", vec_oe, 0);
    chk("rrst_svc", svc, 0);
    chk("rrst_int_n", int_n, 1);
    chk("rrst_state", dut.u_dec.O_STATE, NORM);
    rst = 0; m1_n = 1; iorq_n = 1;
    m_svc = 0; hist.delete(); exp_q.delete();
    en_cycle();
    check_idle("post_rst");

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 6))
        0: set_req(4'($urandom_range(0, 15)));
        1: do_inta();
        2, 3: m1_fetch(pool[$urandom_range(0, 7)]);
        4: mem_read(8'($urandom_range(0, 255)));
        5: begin
          m1_fetch(8'hED);
          m1_fetch(8'h4D);
        end
        default: begin
          iei = ($urandom_range(0, 7) != 0);
          en_cycle();
        end
      endcase
      en_cycle();
      check_idle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/z80_daisy_ctrl.md
Name: z80_daisy_ctrl

Overview:
- Parametrised Z80 mode-2 daisy-chain interrupt controller for NCH local interrupt sources.
- Snoops CPU M1 opcode fetches with full prefix tracking (CB, DD/FD, ED) and decodes RETI (ED 4D) and RETN (ED 45).
- Manages per-channel pending/in-service state, drives the IEI/IEO chain and INT_n, and supplies the mode-2 vector during INTA.
- Sits between the CPU bus and peripherals such as the CTC and PIO.

Parameters:
- NCH, 4, number of local channels; channel 0 has the highest priority.

Ports:
- I_CLK  in  1  system clock.
- I_RESET  in  1  synchronous, active-high reset.
- I_CLKEN  in  1  CPU clock enable; all state advances only on enabled edges.
- I_M1_n  in  1  CPU M1.
- I_MREQ_n  in  1  CPU MREQ.
- I_IORQ_n  in  1  CPU IORQ.
- I_D  in  8  CPU data bus, as read.
- I_IEI  in  1  chain enable from the upstream device.
- I_REQ  in  NCH  level interrupt request per channel.
- I_VEC  in  8*NCH  vector per channel; channel i uses bits [8i+7:8i].
- O_INT_n  out  1  interrupt request to the CPU, active low.
- O_IEO  out  1  chain enable to the downstream device.
- O_VEC  out  8  vector for the acknowledged channel.
- O_VEC_OE  out  1  vector drive enable.
- O_ACK  out  NCH  one-hot acknowledge pulse.
- O_SVC  out  NCH  in-service flags.
- O_RETI  out  1  RETI decoded pulse.
- O_RETN  out  1  RETN decoded pulse.

Behaviour:
- Reset: all registers cleared; prefix state NORM.
  - Outputs: O_INT_n=1, O_VEC_OE=0, O_VEC=0, O_ACK=0, O_SVC=0, O_RETI=0, O_RETN=0.
  - O_IEO=I_IEI.
  - Reset applied mid-INTA or mid-service clears everything immediately.
- Signals: fetch = ~M1_n & ~MREQ_n; inta = ~M1_n & ~IORQ_n; fetch_r and inta_r are registered on enabled edges.
- Opcode capture: on every enabled edge with fetch=1, latch I_D into op. A fetch end (fetch_r & ~fetch) processes op.
- Prefix FSM (advances once per fetch end):
  - NORM: CB->CBP, ED->EDP, DD/FD->IXP, else NORM.
  - IXP: CB->NORM (the displacement and opcode bytes are not M1 fetches), ED->EDP, DD/FD->IXP, else NORM.
  - CBP: any byte -> NORM. A CB-prefixed ED or CB is an opcode, not a prefix.
  - EDP: 4D -> NORM and pulse O_RETI; 45 -> NORM and pulse O_RETN; else NORM.
- Pulse width: O_RETI/O_RETN are high from the processing edge until the next enabled edge (one CLKEN period). Latency is one enabled edge after the fetch ends.
- Chain: ie[0]=I_IEI; ie[i+1]=ie[i] & ~svc[i] & ~(pend[i] & fetch). O_IEO=ie[NCH], combinational.
- Pending:
  - pend[i] follows I_REQ[i] while svc[i]=0 and inta=0.
  - pend is frozen during inta.
  - I_REQ dropped before acknowledge clears pend (level semantics).
- Interrupt request: O_INT_n = ~|(pend & ie[NCH-1:0]), combinational.
- Acknowledge, on the enabled edge where inta & ~inta_r:
  - k = lowest index with pend[k] & ie[k].
  - pend[k]<=0, svc[k]<=1, O_ACK[k] pulses for one CLKEN period.
  - O_VEC<=I_VEC[k], O_VEC_OE<=1.
  - If no eligible channel: O_VEC_OE stays 0, no state change (an upstream or downstream device answers).
- Vector release: O_VEC_OE clears on the first enabled edge with inta=0.
- RETI service clear: clear svc[k] for the lowest k with svc[k] & ie[k]. If none, no change (RETI belongs to another device).
- RETN: pulse only; svc is unchanged.
- Same channel re-request: I_REQ while svc[i]=1 is ignored until the RETI clears svc; a held level then re-pends on the next enabled edge.
- Simultaneous events: INTA and a fetch end cannot coincide. If I_RESET coincides with any event, reset wins.

Decomposition:
- Package z80_bus_pkg:
  - Opcode constants OP_CB=8'hCB, OP_ED=8'hED, OP_DD=8'hDD, OP_FD=8'hFD, OP_RETI2=8'h4D, OP_RETN2=8'h45.
  - Prefix-state enum {NORM, CBP, IXP, EDP}.
- Sub-module z80_op_decoder: fetch capture, prefix FSM, RETI/RETN pulses. Reusable by the CTC and PIO.
- Top level: chain, pend/svc arrays, acknowledge and vector logic.

Test Plan:
- NCH=4, I_IEI=1, I_REQ=4'b0100, I_VEC[2]=8'h24, INTA cycle -> O_INT_n=0 before INTA; O_ACK=4'b0100; O_VEC=24 with O_VEC_OE=1 for the INTA duration; O_SVC=4'b0100; O_IEO=0.
- Fetch ED then 4D with svc=4'b0100 -> O_RETI one CLKEN period; O_SVC=0; O_IEO=1.
- Fetch sequences:
  - CB ED 4D -> no RETI.
  - DD CB (plus two non-M1 reads) then ED 4D -> O_RETI=1.
  - DD ED 4D -> O_RETI=1.
  - ED 45 -> O_RETN=1, O_SVC unchanged.
- Channel 3 in service, I_REQ[1] raised, INTA -> ACK[1]; O_SVC=4'b1010; the first RETI clears bit 1 only, the second RETI clears bit 3.
- I_IEI=0 with I_REQ=4'b0001 -> O_INT_n=1, O_IEO=0; INTA yields O_VEC_OE=0 and no ACK.
- I_RESET asserted mid-INTA with svc=4'b0011 -> next edge: O_VEC_OE=0, O_SVC=0, O_INT_n=1, prefix state NORM.
